// File: rtl/sprite_hit_arbiter.sv
// Sprite hit arbiter: collects per-sprite hit events into a pending vector and
// grants one sprite at a time via a registered valid/ready output stage.
module sprite_hit_arbiter #(
  parameter int N_SPRITES = 14,
  parameter int IDX_W     = 4,
  parameter int MODE      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SPRITES-1:0] hit,
  input  logic                 clear_all,
  input  logic                 sel_ready,
  output logic                 sel_valid,
  output logic [IDX_W-1:0]     sel_idx,
  output logic [N_SPRITES-1:0] pending,
  output logic                 overflow,
  output logic                 state_dbg
);

  localparam int LG_W = $clog2(N_SPRITES);

  generate
    if (N_SPRITES < 2 || N_SPRITES > 31) begin : g_bad_n
      $error("sprite_hit_arbiter: N_SPRITES must be in 2..31");
    end
    if ((1 << IDX_W) <= N_SPRITES) begin : g_bad_idx
      $error("sprite_hit_arbiter: IDX_W too narrow for N_SPRITES");
    end
  endgenerate

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                 state;
  logic [LG_W-1:0]        last_grant;
  logic [LG_W-1:0]        winner;
  logic [LG_W-1:0]        rr_hi;
  logic [LG_W-1:0]        rr_lo;
  logic                   rr_hi_found;
  logic                   any_pending;
  logic                   load;
  logic [N_SPRITES-1:0]   grant_mask;

  // Winner is taken from registered pending only; hit never bypasses to sel_idx.
  always_comb begin
    winner      = '0;
    rr_hi       = '0;
    rr_lo       = '0;
    rr_hi_found = 1'b0;
    if (MODE == 0) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (pending[i]) winner = LG_W'(i);
      end
    end else begin
      // Lowest set bit above last_grant, else wrap to lowest set bit overall.
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
        if (pending[i]) rr_lo = LG_W'(i);
        if (pending[i] && (LG_W'(i) > last_grant)) begin
          rr_hi       = LG_W'(i);
          rr_hi_found = 1'b1;
        end
      end
      winner = rr_hi_found ? rr_hi : rr_lo;
    end
  end

  // Handshake: sel_idx is offered while sel_valid=1 and must stay stable until
  // the cycle sel_ready=1; that edge retires it and may load the next winner.
  assign any_pending = |pending;
  assign load        = !clear_all && any_pending && ((state == EMPTY) || sel_ready);

  always_comb begin
    grant_mask = '0;
    if (load) grant_mask[winner] = 1'b1;
  end

  assign sel_valid = (state == FULL);
  assign state_dbg = (state == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      sel_idx    <= '0;
      pending    <= '0;
      overflow   <= 1'b0;
      last_grant <= LG_W'(N_SPRITES - 1);
    end else if (clear_all) begin
      state    <= EMPTY;
      sel_idx  <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      // A hit on the bit granted this edge is a new event and stays pending.
      pending  <= (pending & ~grant_mask) | hit;
      overflow <= |(hit & pending & ~grant_mask);
      case (state)
        EMPTY: begin
          if (load) begin
            state      <= FULL;
            sel_idx    <= IDX_W'(winner) + IDX_W'(1);
            last_grant <= winner;
          end
        end
        FULL: begin
          if (load) begin
            sel_idx    <= IDX_W'(winner) + IDX_W'(1);
            last_grant <= winner;
          end else if (sel_ready) begin
            state   <= EMPTY;
            sel_idx <= '0;
          end
        end
        default: begin
          state   <= EMPTY;
          sel_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_hit_arbiter.sv
// Bench for sprite_hit_arbiter: fixed-priority and round-robin instances share
// stimulus; a rule-level model is checked every cycle plus literal vectors.
module tb_sprite_hit_arbiter;

  localparam int N  = 14;
  localparam int IW = 4;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   hit = '0;
  logic           clear_all = 1'b0;
  logic           sel_ready = 1'b0;
  logic           check_en = 1'b0;

  logic           sel_valid [2];
  logic [IW-1:0]  sel_idx   [2];
  logic [N-1:0]   pending   [2];
  logic           overflow  [2];
  logic           state_dbg [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sprite_hit_arbiter #(.N_SPRITES(N), .IDX_W(IW), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .hit(hit), .clear_all(clear_all), .sel_ready(sel_ready),
    .sel_valid(sel_valid[0]), .sel_idx(sel_idx[0]), .pending(pending[0]),
    .overflow(overflow[0]), .state_dbg(state_dbg[0])
  );

  sprite_hit_arbiter #(.N_SPRITES(N), .IDX_W(IW), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .hit(hit), .clear_all(clear_all), .sel_ready(sel_ready),
    .sel_valid(sel_valid[1]), .sel_idx(sel_idx[1]), .pending(pending[1]),
    .overflow(overflow[1]), .state_dbg(state_dbg[1])
  );

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_pend  [2];
  logic         m_valid [2];
  int           m_idx   [2];
  logic         m_ovf   [2];
  int           m_last  [2];
  int           mw;
  bit           mtake;
  logic [N-1:0] mgm;

  // Sprite chosen from a pending set: highest index, or next after last (mod N).
  function automatic int pick(input int mode, input logic [N-1:0] p, input int last);
    if (mode == 0) begin
      for (int i = N - 1; i >= 0; i--) if (p[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (p[j]) return j;
      end
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = '0; m_valid[m] = 1'b0; m_idx[m] = 0; m_ovf[m] = 1'b0; m_last[m] = N - 1;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        mw    = pick(m, m_pend[m], m_last[m]);
        mtake = !clear_all && (mw >= 0) && (!m_valid[m] || sel_ready);
        mgm   = '0;
        if (mtake) mgm[mw] = 1'b1;
        if (clear_all) begin
          m_pend[m] = '0; m_ovf[m] = 1'b0; m_valid[m] = 1'b0; m_idx[m] = 0;
        end else begin
          m_ovf[m]  = |(hit & m_pend[m] & ~mgm);
          m_pend[m] = (m_pend[m] & ~mgm) | hit;
          if (mtake) begin
            m_valid[m] = 1'b1; m_idx[m] = mw + 1; m_last[m] = mw;
          end else if (m_valid[m] && sel_ready) begin
            m_valid[m] = 1'b0; m_idx[m] = 0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("model_valid_u%0d", m), 32'(sel_valid[m]), 32'(m_valid[m]));
        check($sformatf("model_idx_u%0d", m), 32'(sel_idx[m]), 32'(m_idx[m]));
        check($sformatf("model_pending_u%0d", m), 32'(pending[m]), 32'(m_pend[m]));
        check($sformatf("model_overflow_u%0d", m), 32'(overflow[m]), 32'(m_ovf[m]));
        check($sformatf("model_state_u%0d", m), 32'(state_dbg[m]), 32'(m_valid[m]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; hit = '0; clear_all = 1'b0; sel_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  initial begin
    do_reset();
    check("rst_valid", 32'(sel_valid[0]), 0);
    check("rst_idx", 32'(sel_idx[1]), 0);
    check("rst_pending", 32'(pending[0]), 0);
    check("rst_overflow", 32'(overflow[1]), 0);

    // Two-sprite pulse, consumer always ready.
    sel_ready = 1'b1; hit = 14'h0005;
    tick();
    hit = '0;
    check("t1_pend_e1", 32'(pending[0]), 32'h5);
    check("t1_valid_e1", 32'(sel_valid[0]), 0);
    tick();
    check("t1_valid_e2", 32'(sel_valid[0]), 1);
    check("t1_idx_e2_fp", 32'(sel_idx[0]), 3);
    check("t1_idx_e2_rr", 32'(sel_idx[1]), 1);
    tick();
    check("t1_idx_e3_fp", 32'(sel_idx[0]), 1);
    check("t1_idx_e3_rr", 32'(sel_idx[1]), 3);
    tick();
    check("t1_valid_e4", 32'(sel_valid[0]), 0);
    check("t1_idx_e4", 32'(sel_idx[0]), 0);

    // All sprites at once: round-robin sweeps 1..14 without bubbles.
    do_reset();
    sel_ready = 1'b1; hit = 14'h3FFF;
    tick();
    hit = '0;
    for (int k = 1; k <= N; k++) begin
      tick();
      check($sformatf("t2_rr_valid_%0d", k), 32'(sel_valid[1]), 1);
      check($sformatf("t2_rr_idx_%0d", k), 32'(sel_idx[1]), 32'(k));
      check($sformatf("t2_fp_idx_%0d", k), 32'(sel_idx[0]), 32'(15 - k));
    end
    tick();
    check("t2_rr_empty", 32'(sel_valid[1]), 0);
    check("t2_fp_empty", 32'(sel_valid[0]), 0);

    // Back-pressure holds sprite 7 while other hits accumulate.
    do_reset();
    hit = 14'h0040;
    tick();
    hit = 14'h0003;
    tick();
    hit = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_hold_idx_fp", 32'(sel_idx[0]), 7);
      check("t3_hold_idx_rr", 32'(sel_idx[1]), 7);
      check("t3_hold_valid", 32'(sel_valid[0]), 1);
      check("t3_hold_pend", 32'(pending[0]), 32'h3);
    end
    sel_ready = 1'b1;
    tick();
    check("t3_next_fp", 32'(sel_idx[0]), 2);
    check("t3_next_rr", 32'(sel_idx[1]), 1);
    tick();
    check("t3_last_fp", 32'(sel_idx[0]), 1);
    check("t3_last_rr", 32'(sel_idx[1]), 2);
    tick();
    check("t3_empty", 32'(sel_valid[1]), 0);

    // Repeated hit on pending sprite 5 gives one overflow pulse, one grant.
    do_reset();
    hit = 14'h0100;
    tick();
    hit = 14'h0010;
    tick();
    check("t4_idx9", 32'(sel_idx[0]), 9);
    check("t4_ovf_first", 32'(overflow[0]), 0);
    hit = '0;
    tick();
    check("t4_ovf_gap", 32'(overflow[1]), 0);
    hit = 14'h0010;
    tick();
    hit = '0;
    check("t4_ovf_pulse_fp", 32'(overflow[0]), 1);
    check("t4_ovf_pulse_rr", 32'(overflow[1]), 1);
    check("t4_pend_bit4", 32'(pending[0]), 32'h10);
    tick();
    check("t4_ovf_drop", 32'(overflow[0]), 0);
    check("t4_idx_held", 32'(sel_idx[0]), 9);
    sel_ready = 1'b1;
    tick();
    check("t4_grant5_fp", 32'(sel_idx[0]), 5);
    check("t4_grant5_rr", 32'(sel_idx[1]), 5);
    tick();
    check("t4_empty", 32'(sel_valid[0]), 0);
    check("t4_no_regrant", 32'(pending[0]), 0);

    // Flush while full, with a same-cycle hit that must be discarded.
    do_reset();
    hit = 14'h0004;
    tick();
    hit = 14'h0102;
    tick();
    check("t5_pend_pre", 32'(pending[0]), 32'h102);
    check("t5_idx_pre", 32'(sel_idx[0]), 3);
    clear_all = 1'b1; sel_ready = 1'b1; hit = 14'h0001;
    tick();
    clear_all = 1'b0; hit = '0;
    check("t5_pend_clr", 32'(pending[0]), 0);
    check("t5_valid_clr", 32'(sel_valid[0]), 0);
    check("t5_idx_clr", 32'(sel_idx[1]), 0);
    check("t5_ovf_clr", 32'(overflow[0]), 0);
    tick();
    check("t5_stay_empty", 32'(sel_valid[1]), 0);
    hit = 14'h0009;
    tick();
    hit = '0;
    tick();
    check("t5_rr_keeps_last", 32'(sel_idx[1]), 4);
    tick();
    check("t5_rr_wrap", 32'(sel_idx[1]), 1);

    // Asynchronous reset mid-cycle while holding a grant.
    do_reset();
    hit = 14'h0020;
    tick();
    hit = 14'h0001;
    tick();
    hit = '0;
    check("t6_full", 32'(sel_idx[0]), 6);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(sel_valid[0]), 0);
    check("t6_async_idx", 32'(sel_idx[0]), 0);
    check("t6_async_pend", 32'(pending[1]), 0);
    tick();
    reset = 1'b0; sel_ready = 1'b1;
    repeat (3) tick();
    check("t6_post_valid", 32'(sel_valid[0]), 0);
    check("t6_post_valid_rr", 32'(sel_valid[1]), 0);

    @(posedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
